// File: rtl/rotation_pkg.sv
// Shared types and constants for the rotation decoder: FSM state encoding,
// direction values and the default partner-edge timeout.
package rotation_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEEN_A = 2'd1,
    SEEN_B = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/sensor_edge_sync.sv
// Two-flop synchroniser for one asynchronous sensor line, followed by a
// registered history bit that yields a single-cycle rising-edge strobe.
module sensor_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbour, forming a true shift chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/rotation_decoder.sv
// Decodes rotation direction from the order of sensorA/sensorB rising edges and
// keeps a signed revolution count. Optional period measurement: ROTATION_PERIOD_EN.
module rotation_decoder
  import rotation_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int PER_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sensorA,
  input  logic             sensorB,
  output logic             dir,
  output logic             rev_valid,
  output logic [CNT_W-1:0] rev_count,
  output logic             fault,
  output logic [PER_W-1:0] period
);

  localparam int               TMR_W    = $clog2(TIMEOUT) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  logic w_rise_a;
  logic w_rise_b;
  logic w_both;
  logic w_in_seen;
  logic w_own_rise;
  logic w_partner_rise;
  logic w_decode;
  logic w_decode_dir;

  state_t           r_state;
  logic [TMR_W-1:0] r_timer;
  logic             r_dir;
  logic             r_rev_valid;
  logic             r_fault;
  logic [CNT_W-1:0] r_count;

  sensor_edge_sync u_sync_a (
    .clk    (clk),
    .reset  (reset),
    .i_raw  (sensorA),
    .o_rise (w_rise_a)
  );

  sensor_edge_sync u_sync_b (
    .clk    (clk),
    .reset  (reset),
    .i_raw  (sensorB),
    .o_rise (w_rise_b)
  );

  // "Own" is the sensor that opened the sequence; "partner" completes it.
  assign w_both         = w_rise_a & w_rise_b;
  assign w_in_seen      = (r_state == SEEN_A) || (r_state == SEEN_B);
  assign w_own_rise     = (r_state == SEEN_A) ? w_rise_a : w_rise_b;
  assign w_partner_rise = (r_state == SEEN_A) ? w_rise_b : w_rise_a;
  assign w_decode       = w_in_seen & ~w_both & ~w_own_rise & w_partner_rise;
  assign w_decode_dir   = (r_state == SEEN_A) ? DIR_LEFT : DIR_RIGHT;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_dir       <= 1'b0;
      r_rev_valid <= 1'b0;
      r_fault     <= 1'b0;
      r_count     <= '0;
    end else begin
      r_rev_valid <= 1'b0;
      r_fault     <= 1'b0;
      case (r_state)
        IDLE: begin
          r_timer <= '0;
          if (w_both)
            r_fault <= 1'b1;
          else if (w_rise_a)
            r_state <= SEEN_A;
          else if (w_rise_b)
            r_state <= SEEN_B;
        end
        SEEN_A, SEEN_B: begin
          if (w_both) begin
            r_fault <= 1'b1;
            r_state <= IDLE;
            r_timer <= '0;
          end else if (w_own_rise) begin
            r_timer <= '0;
          end else if (w_decode) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_rev_valid <= 1'b1;
            r_dir       <= w_decode_dir;
            r_count     <= (w_decode_dir == DIR_LEFT) ? r_count + CNT_W'(1)
                                                      : r_count - CNT_W'(1);
          end else if (r_timer == TMR_LAST) begin
            r_fault <= 1'b1;
            r_state <= IDLE;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_timer <= '0;
        end
      endcase
    end
  end

  assign dir       = r_dir;
  assign rev_valid = r_rev_valid;
  assign fault     = r_fault;
  assign rev_count = r_count;

`ifdef ROTATION_PERIOD_EN
  logic [PER_W-1:0] r_per_cnt;
  logic [PER_W-1:0] r_period;
  logic             r_dir_known;

  // r_dir still holds the previous decode here; the first decode after reset
  // has no predecessor, so it only restarts the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_per_cnt   <= '0;
      r_period    <= '0;
      r_dir_known <= 1'b0;
    end else if (w_decode) begin
      if (r_dir_known && (w_decode_dir == r_dir))
        r_period <= r_per_cnt;
      r_per_cnt   <= PER_W'(1);
      r_dir_known <= 1'b1;
    end else if (r_per_cnt != '1) begin
      r_per_cnt <= r_per_cnt + PER_W'(1);
    end
  end

  assign period = r_period;
`else
  assign period = '0;
`endif

endmodule

// File: tb/tb_rotation_decoder.sv
// Directed bench for rotation_decoder: a scoreboard queue of expected pulses
// (cycle, kind, dir, count) checked by a negedge monitor; a CNT_W=4 twin covers wrap.
module tb_rotation_decoder;

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic        sensorA = 1'b0;
  logic        sensorB = 1'b0;
  logic        dir, rev_valid, fault;
  logic [15:0] rev_count, period;
  logic        dir4, rev_valid4, fault4;
  logic [3:0]  rev_count4;
  logic [15:0] period4;

  typedef struct {
    bit          is_fault;
    int          cyc;
    bit          dir;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } ev_t;

  ev_t         sb[$];
  ev_t         mon_ev;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [15:0] m_cnt   = '0;
  bit          m_dir   = 1'b0;

  rotation_decoder u_dut (
    .clk       (clk),
    .reset     (reset),
    .sensorA   (sensorA),
    .sensorB   (sensorB),
    .dir       (dir),
    .rev_valid (rev_valid),
    .rev_count (rev_count),
    .fault     (fault),
    .period    (period)
  );

  rotation_decoder #(.CNT_W(4)) u_dut4 (
    .clk       (clk),
    .reset     (reset),
    .sensorA   (sensorA),
    .sensorB   (sensorB),
    .dir       (dir4),
    .rev_valid (rev_valid4),
    .rev_count (rev_count4),
    .fault     (fault4),
    .period    (period4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_rev(input bit left, input int at);
    m_dir = left;
    m_cnt = left ? m_cnt + 16'd1 : m_cnt - 16'd1;
    sb.push_back('{is_fault: 1'b0, cyc: at, dir: left, cnt: m_cnt, cnt4: m_cnt[3:0]});
  endtask

  task automatic push_fault(input int at);
    sb.push_back('{is_fault: 1'b1, cyc: at, dir: m_dir, cnt: m_cnt, cnt4: m_cnt[3:0]});
  endtask

  // First sensor high 4 cycles, low 2, partner high 4, then a gap.
  // The partner edge is decoded 3 cycles after it is driven.
  task automatic rev_seq(input bit left, input int gap);
    if (left) sensorA = 1'b1; else sensorB = 1'b1;
    tick(4);
    if (left) sensorA = 1'b0; else sensorB = 1'b0;
    tick(2);
    if (left) sensorB = 1'b1; else sensorA = 1'b1;
    push_rev(left, cyc + 3);
    tick(4);
    if (left) sensorB = 1'b0; else sensorA = 1'b0;
    tick(gap);
  endtask

  always @(negedge clk) begin
    if (rev_valid || fault) begin
      check("pulse_overlap", {31'd0, rev_valid & fault}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", {30'd0, rev_valid, fault}, 32'd0);
      end else begin
        mon_ev = sb.pop_front();
        check("pulse_kind",   {30'd0, rev_valid, fault},   mon_ev.is_fault ? 32'd1 : 32'd2);
        check("pulse_cycle",  cyc,                         mon_ev.cyc);
        check("pulse_dir",    {31'd0, dir},                {31'd0, mon_ev.dir});
        check("pulse_count",  {16'd0, rev_count},          {16'd0, mon_ev.cnt});
        check("narrow_kind",  {30'd0, rev_valid4, fault4}, mon_ev.is_fault ? 32'd1 : 32'd2);
        check("narrow_count", {28'd0, rev_count4},         {28'd0, mon_ev.cnt4});
      end
    end else if (rev_valid4 || fault4) begin
      check("narrow_unexpected", {30'd0, rev_valid4, fault4}, 32'd0);
    end
  end

  initial begin
    int c0;
    reset = 1'b1;
    tick(3);
    check("reset_dir",       {31'd0, dir},       32'd0);
    check("reset_rev_valid", {31'd0, rev_valid}, 32'd0);
    check("reset_fault",     {31'd0, fault},     32'd0);
    check("reset_count",     {16'd0, rev_count}, 32'd0);
    check("reset_period",    {16'd0, period},    32'd0);
    check("reset_count4",    {28'd0, rev_count4}, 32'd0);

    reset = 1'b0;
    tick(20);
    check("idle_count", {16'd0, rev_count}, 32'd0);
    check("idle_dir",   {31'd0, dir},       32'd0);

    repeat (3) rev_seq(1'b1, 4);
    check("left3_dir",   {31'd0, dir},       32'd1);
    check("left3_count", {16'd0, rev_count}, 32'd3);

    repeat (2) rev_seq(1'b0, 4);
    check("right2_dir",   {31'd0, dir},       32'd0);
    check("right2_count", {16'd0, rev_count}, 32'd1);

    // A rises, partner never comes: SEEN_A entered 3 cycles later, fault 64 after that.
    sensorA = 1'b1;
    push_fault(cyc + 3 + 64);
    tick(70);
    sensorA = 1'b0;
    tick(4);
    check("timeout_count", {16'd0, rev_count}, 32'd1);
    check("timeout_dir",   {31'd0, dir},       32'd0);

    sensorA = 1'b1;
    sensorB = 1'b1;
    push_fault(cyc + 3);
    tick(4);
    sensorA = 1'b0;
    sensorB = 1'b0;
    tick(4);
    check("simul_count", {16'd0, rev_count}, 32'd1);

    // A re-rise 40 cycles in restarts the timer, so B at 80 still decodes.
    c0 = cyc;
    sensorA = 1'b1;
    tick(4);
    sensorA = 1'b0;
    tick(36);
    sensorA = 1'b1;
    tick(4);
    sensorA = 1'b0;
    tick(36);
    sensorB = 1'b1;
    check("bounce_spacing", cyc - c0, 32'd80);
    push_rev(1'b1, cyc + 3);
    tick(4);
    sensorB = 1'b0;
    tick(4);
    check("bounce_count", {16'd0, rev_count}, 32'd2);

    repeat (5) rev_seq(1'b1, 4);
    check("narrow_at_max", {28'd0, rev_count4}, 32'd7);
    rev_seq(1'b1, 4);
    check("narrow_wrap", {28'd0, rev_count4}, 32'h8);
    check("wide_no_wrap", {16'd0, rev_count}, 32'd8);

    // Reset while in SEEN_B discards the sequence silently.
    sensorB = 1'b1;
    tick(5);
    reset   = 1'b1;
    sensorB = 1'b0;
    tick(3);
    reset = 1'b0;
    m_cnt = '0;
    m_dir = 1'b0;
    sensorA = 1'b1;
    tick(4);
    sensorA = 1'b0;
    tick(4);
    // That A rise opened a fresh sequence; let it time out.
    push_fault(cyc - 8 + 3 + 64);
    tick(64);
    check("midreset_count",  {16'd0, rev_count},  32'd0);
    check("midreset_count4", {28'd0, rev_count4}, 32'd0);
    check("midreset_dir",    {31'd0, dir},        32'd0);

`ifdef ROTATION_PERIOD_EN
    rev_seq(1'b1, 30);
    rev_seq(1'b1, 30);
    check("period_left", {16'd0, period}, 32'd40);
    rev_seq(1'b0, 30);
    check("period_hold", {16'd0, period}, 32'd40);
    check("period_narrow", {16'd0, period4}, 32'd40);
`else
    rev_seq(1'b1, 30);
    rev_seq(1'b1, 30);
    check("period_tied", {16'd0, period},  32'd0);
    check("period4_tied", {16'd0, period4}, 32'd0);
`endif

    tick(10);
    check("pending_events", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rotation_decoder.md
Name: rotation_decoder

Overview:
- Downstream consumer of the red-mark rotation model's sensorA/sensorB outputs.
- Synchronises both sensor lines, detects rising edges, and infers rotation direction from edge order (A then B = left, B then A = right).
- Maintains a signed revolution count, flags ordering faults, and optionally measures the revolution period in clk cycles.
- Output feeds the lab's display/monitor stage.

Parameters:
- CNT_W, 16, width of the signed revolution counter (two's complement).
- TIMEOUT, 64, maximum clk cycles allowed between the first sensor edge and the partner edge.
- PER_W, 16, width of the period measurement (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock; sensors must hold each level >= 2 clk cycles.
- reset  input  1  synchronous, active-high reset.
- sensorA  input  1  raw sensor A from the rotation stage; asynchronous to clk.
- sensorB  input  1  raw sensor B from the rotation stage; asynchronous to clk.
- dir  output  1  last decoded direction: 1 = left, 0 = right.
- rev_valid  output  1  one-cycle pulse when a revolution is decoded.
- rev_count  output  CNT_W  signed count: +1 per left revolution, -1 per right revolution.
- fault  output  1  one-cycle pulse on timeout or simultaneous A/B edge.
- period  output  PER_W  clk cycles between the last two same-direction revolutions (feature only).

Behaviour:
- Reset (synchronous, active-high, sampled on clk rising edge): all outputs 0, FSM to IDLE, synchroniser flops and edge-detect history to 0, timer 0.
- Input path: 2-flop synchroniser per sensor, then a registered previous value. riseX = sync & ~prev.
- Latency: 3 clk cycles from a raw edge to FSM action. rev_valid and rev_count update on the cycle the partner edge is seen, i.e. 3 cycles after the second raw edge.
- FSM states: IDLE, SEEN_A, SEEN_B.
  - IDLE: riseA only -> SEEN_A; riseB only -> SEEN_B; both -> fault pulse, stay IDLE. Timer cleared on entry to SEEN_A/SEEN_B.
  - SEEN_A: riseB only -> IDLE, dir=1, rev_count+1, rev_valid pulse.
  - SEEN_A: riseA again -> stay SEEN_A, timer restarts (bounce/back-off, no count).
  - SEEN_A: both rise -> fault, IDLE.
  - SEEN_A: timer reaches TIMEOUT-1 with no edge -> fault, IDLE.
  - SEEN_B: mirror of SEEN_A; partner riseA -> dir=0, rev_count-1, rev_valid pulse.
- Timer: counts while in SEEN_A/SEEN_B, width clog2(TIMEOUT)+1, held at 0 in IDLE.
- rev_count wraps two's complement (no saturation): max positive +1 -> most negative, and vice versa.
- dir holds its last value between decodes; it is unchanged by fault.
- Reset mid-sequence (e.g. in SEEN_A): sequence discarded, no rev_valid, no fault.
- rev_valid and fault are never asserted in the same cycle.

Optional Feature:
- Macro ROTATION_PERIOD_EN.
- Defined:
  - A free-running PER_W counter saturates at all-ones.
  - On each rev_valid whose dir equals the previous decoded dir, period <= counter and the counter restarts at 1.
  - On a direction change, period is not updated and the counter restarts at 1.
  - Reset clears the counter and period.
- Undefined: period is tied to 0 and no counter logic exists; the port remains for a uniform interface.

Decomposition:
- Shared package rotation_pkg:
  - State enum (IDLE=2'd0, SEEN_A=2'd1, SEEN_B=2'd2).
  - Direction constants DIR_LEFT=1'b1, DIR_RIGHT=1'b0.
  - Default TIMEOUT value.
- One natural sub-module: sensor_edge_sync (2-flop synchroniser plus rise detect), instantiated twice.

Test Plan:
- Reset then idle inputs for 20 cycles -> all outputs 0, no pulses.
- Left sequence: sensorA high 4 cycles, low, then sensorB high 4 cycles; repeat 3 times -> three rev_valid pulses, dir=1, rev_count=3.
- Then 2 right sequences (B before A) -> dir=0, rev_count=1, no fault.
- sensorA rise, no B within 64 cycles -> single fault pulse at cycle 64 after SEEN_A entry, state IDLE, rev_count unchanged.
- sensorA and sensorB rise in the same cycle -> fault pulse, no count. Also: with CNT_W=4 from rev_count=7, one left sequence -> rev_count=-8.
- With ROTATION_PERIOD_EN, left revolutions spaced 40 cycles apart -> period=40 after the second decode; a right revolution then leaves period=40 unchanged. Reset asserted in SEEN_B -> no pulses, rev_count=0.
